// File: rtl/sha256_pkg.sv
// Shared constants and encodings for the SHA-256 message feeder.
package sha256_pkg;

    localparam int unsigned SHA256_BLOCK_BYTES = 64;
    localparam int unsigned SHA256_LEN_BYTES   = 8;
    localparam logic [7:0]  SHA256_PAD_BYTE    = 8'h80;
    localparam int unsigned LEN_FIELD_START    = SHA256_BLOCK_BYTES - SHA256_LEN_BYTES;

    typedef enum logic [2:0] {
        ST_FILL,
        ST_PAD,
        ST_EXTRA,
        ST_SEND,
        ST_WAIT,
        ST_OUT
    } feeder_state_e;

    // Where the FSM goes once the core reports completion of the block in flight.
    typedef enum logic [1:0] {
        NEXT_FILL,
        NEXT_EXTRA,
        NEXT_OUT
    } wait_next_e;

endpackage

// File: rtl/sha256_msg_feeder_if.sv
// Byte-stream input, core handshake and digest handshake of the message feeder.
interface sha256_msg_feeder_if;
    import sha256_pkg::*;

    logic [7:0]                      s_data;
    logic                            s_valid;
    logic                            s_last;
    logic                            s_nobyte;
    logic                            s_ready;

    logic [SHA256_BLOCK_BYTES*8-1:0] core_block;
    logic                            core_start;
    logic                            core_first_run;
    logic                            core_ready;
    logic [255:0]                    core_hash;

    logic [255:0]                    digest;
    logic                            digest_valid;
    logic                            digest_ack;

    modport master (
        input  s_data, s_valid, s_last, s_nobyte, core_ready, core_hash, digest_ack,
        output s_ready, core_block, core_start, core_first_run, digest, digest_valid
    );

    modport slave (
        output s_data, s_valid, s_last, s_nobyte, core_ready, core_hash, digest_ack,
        input  s_ready, core_block, core_start, core_first_run, digest, digest_valid
    );

endinterface

// File: rtl/sha256_msg_feeder_block_buf.sv
// 64-byte block buffer: byte writes, padding fill and length insertion, big-endian flatten.
module sha256_block_buf
    import sha256_pkg::*;
(
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            clear,
    input  logic                            wr_en,
    input  logic [5:0]                      wr_idx,
    input  logic [7:0]                      wr_data,
    input  logic                            fill_en,
    input  logic [6:0]                      fill_pos,
    input  logic                            fill_mark,
    input  logic                            fill_len,
    input  logic [63:0]                     len_bits,
    output logic [SHA256_BLOCK_BYTES*8-1:0] block
);

    logic [7:0] mem_q [SHA256_BLOCK_BYTES];
    logic [7:0] mem_d [SHA256_BLOCK_BYTES];

    // Next buffer contents: clear, single byte write, or pad/length fill from fill_pos.
    always_comb begin
        mem_d = mem_q;
        if (clear) begin
            mem_d = '{default: '0};
        end else if (wr_en) begin
            mem_d[wr_idx] = wr_data;
        end else if (fill_en) begin
            // fill_pos == 64 leaves the data bytes untouched (full block, padding goes next block).
            for (int unsigned i = 0; i < SHA256_BLOCK_BYTES; i++) begin
                if (fill_mark && (7'(i) == fill_pos)) begin
                    mem_d[6'(i)] = SHA256_PAD_BYTE;
                end else if (7'(i) >= fill_pos) begin
                    mem_d[6'(i)] = '0;
                end
                if (fill_len && (i >= LEN_FIELD_START)) begin
                    mem_d[6'(i)] = len_bits[8*(SHA256_BLOCK_BYTES-1-i) +: 8];
                end
            end
        end
    end

    // Buffer register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q <= '{default: '0};
        end else begin
            mem_q <= mem_d;
        end
    end

    // Byte 0 lands in the most significant byte of the flattened block.
    always_comb begin
        block = '0;
        for (int unsigned i = 0; i < SHA256_BLOCK_BYTES; i++) begin
            block[8*(SHA256_BLOCK_BYTES-1-i) +: 8] = mem_q[6'(i)];
        end
    end

endmodule

// File: rtl/sha256_msg_feeder.sv
// Packs a byte stream into padded SHA-256 blocks, sequences the core, returns the digest.
module sha256_msg_feeder
    import sha256_pkg::*;
#(
    parameter int unsigned BYTE_CNT_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    sha256_msg_feeder_if.master bus
);

    feeder_state_e          state_q, state_d;
    wait_next_e             next_q, next_d;
    logic [5:0]             idx_q, idx_d;
    logic [6:0]             pad_n_q, pad_n_d;
    logic [BYTE_CNT_W-1:0]  cnt_q, cnt_d;
    logic                   first_q, first_d;
    logic                   skip_q, skip_d;
    logic                   extra_mark_q, extra_mark_d;
    logic                   s_ready_q, s_ready_d;
    logic [255:0]           digest_q, digest_d;

    logic                   has_byte;
    logic                   buf_clear;
    logic                   buf_wr;
    logic                   buf_fill;
    logic [6:0]             buf_fill_pos;
    logic                   buf_fill_mark;
    logic                   buf_fill_len;
    logic [63:0]            len_bits;
    logic [SHA256_BLOCK_BYTES*8-1:0] block;

    assign len_bits = 64'(cnt_q) << 3;

    sha256_block_buf u_buf (
        .clk       (clk),
        .rst       (rst),
        .clear     (buf_clear),
        .wr_en     (buf_wr),
        .wr_idx    (idx_q),
        .wr_data   (bus.s_data),
        .fill_en   (buf_fill),
        .fill_pos  (buf_fill_pos),
        .fill_mark (buf_fill_mark),
        .fill_len  (buf_fill_len),
        .len_bits  (len_bits),
        .block     (block)
    );

    // Next-state and buffer control for the fill/pad/send/wait/output sequence.
    always_comb begin
        state_d       = state_q;
        next_d        = next_q;
        idx_d         = idx_q;
        pad_n_d       = pad_n_q;
        cnt_d         = cnt_q;
        first_d       = first_q;
        skip_d        = skip_q;
        extra_mark_d  = extra_mark_q;
        digest_d      = digest_q;
        buf_clear     = 1'b0;
        buf_wr        = 1'b0;
        buf_fill      = 1'b0;
        buf_fill_pos  = '0;
        buf_fill_mark = 1'b0;
        buf_fill_len  = 1'b0;
        has_byte      = !bus.s_nobyte;

        unique case (state_q)
            ST_FILL: begin
                if (bus.s_valid && s_ready_q) begin
                    if (has_byte) begin
                        buf_wr = 1'b1;
                        idx_d  = idx_q + 6'd1;
                        cnt_d  = cnt_q + BYTE_CNT_W'(1);
                    end
                    if (bus.s_last) begin
                        // 7-bit count so a full final block (64) is distinguishable from 0.
                        pad_n_d = {1'b0, idx_q} + {6'b0, has_byte};
                        state_d = ST_PAD;
                    end else if (has_byte && (idx_q == 6'd63)) begin
                        next_d  = NEXT_FILL;
                        state_d = ST_SEND;
                    end
                end
            end
            ST_PAD: begin
                buf_fill      = 1'b1;
                buf_fill_pos  = pad_n_q;
                buf_fill_mark = (pad_n_q != 7'(SHA256_BLOCK_BYTES));
                buf_fill_len  = (pad_n_q < 7'(LEN_FIELD_START));
                extra_mark_d  = (pad_n_q == 7'(SHA256_BLOCK_BYTES));
                next_d        = (pad_n_q < 7'(LEN_FIELD_START)) ? NEXT_OUT : NEXT_EXTRA;
                state_d       = ST_SEND;
            end
            ST_EXTRA: begin
                buf_fill      = 1'b1;
                buf_fill_pos  = '0;
                buf_fill_mark = extra_mark_q;
                buf_fill_len  = 1'b1;
                next_d        = NEXT_OUT;
                state_d       = ST_SEND;
            end
            ST_SEND: begin
                first_d = 1'b0;
                skip_d  = 1'b1;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // The first WAIT cycle still sees the core's stale ready; ignore it.
                if (skip_q) begin
                    skip_d = 1'b0;
                end else if (bus.core_ready) begin
                    unique case (next_q)
                        NEXT_FILL: begin
                            buf_clear = 1'b1;
                            idx_d     = '0;
                            state_d   = ST_FILL;
                        end
                        NEXT_EXTRA: begin
                            state_d = ST_EXTRA;
                        end
                        default: begin
                            digest_d = bus.core_hash;
                            state_d  = ST_OUT;
                        end
                    endcase
                end
            end
            ST_OUT: begin
                if (bus.digest_ack) begin
                    cnt_d     = '0;
                    first_d   = 1'b1;
                    idx_d     = '0;
                    buf_clear = 1'b1;
                    state_d   = ST_FILL;
                end
            end
            default: begin
                state_d = ST_FILL;
            end
        endcase

        s_ready_d = (state_d == ST_FILL);
    end

    // State, counters and handshake registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_FILL;
            next_q       <= NEXT_FILL;
            idx_q        <= '0;
            pad_n_q      <= '0;
            cnt_q        <= '0;
            first_q      <= 1'b1;
            skip_q       <= 1'b0;
            extra_mark_q <= 1'b0;
            s_ready_q    <= 1'b0;
            digest_q     <= '0;
        end else begin
            state_q      <= state_d;
            next_q       <= next_d;
            idx_q        <= idx_d;
            pad_n_q      <= pad_n_d;
            cnt_q        <= cnt_d;
            first_q      <= first_d;
            skip_q       <= skip_d;
            extra_mark_q <= extra_mark_d;
            s_ready_q    <= s_ready_d;
            digest_q     <= digest_d;
        end
    end

    assign bus.s_ready        = s_ready_q;
    assign bus.core_block     = block;
    assign bus.core_start     = (state_q == ST_SEND);
    assign bus.core_first_run = (state_q == ST_SEND) && first_q;
    assign bus.digest         = digest_q;
    assign bus.digest_valid   = (state_q == ST_OUT);

endmodule

// File: tb/tb_sha256_msg_feeder.sv
// Bench for sha256_msg_feeder with a behavioural SHA-256 core and reference hash model.
module tb_sha256_msg_feeder;

    typedef logic [7:0] byte_q_t [$];

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };
    localparam logic [255:0] IV =
        256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
    localparam logic [255:0] KAT_ABC =
        256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] KAT_EMPTY =
        256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
    localparam logic [255:0] KAT_56 =
        256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
    localparam int unsigned CORE_LAT = 6;
    localparam int unsigned LIMIT    = 5000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sha256_msg_feeder_if bus ();

    sha256_msg_feeder #(.BYTE_CNT_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int tests = 0;
    int fails = 0;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] compress(input logic [255:0] h, input logic [511:0] blk);
        logic [31:0] w [64];
        logic [31:0] a, b, c, d, e, f, g, hh, t1, t2, s0, s1;
        for (int t = 0; t < 16; t++) w[t] = blk[511-32*t -: 32];
        for (int t = 16; t < 64; t++) begin
            s0 = rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3);
            s1 = rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10);
            w[t] = w[t-16] + s0 + w[t-7] + s1;
        end
        {a, b, c, d, e, f, g, hh} = h;
        for (int t = 0; t < 64; t++) begin
            t1 = hh + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + K[t] + w[t];
            t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
            hh = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
        end
        return {h[255:224] + a, h[223:192] + b, h[191:160] + c, h[159:128] + d,
                h[127:96] + e, h[95:64] + f, h[63:32] + g, h[31:0] + hh};
    endfunction

    // Reference: pad the whole message as a byte queue, then chain compressions from IV.
    function automatic logic [255:0] sha_ref(input byte_q_t m);
        byte_q_t      p;
        logic [255:0] h;
        logic [511:0] blk;
        logic [63:0]  bits;
        p = m;
        p.push_back(8'h80);
        while ((p.size() % 64) != 56) p.push_back(8'h00);
        bits = 64'(m.size()) * 64'd8;
        for (int i = 7; i >= 0; i--) p.push_back(bits[8*i +: 8]);
        h = IV;
        for (int bi = 0; bi < p.size() / 64; bi++) begin
            for (int j = 0; j < 64; j++) blk[511-8*j -: 8] = p[64*bi+j];
            h = compress(h, blk);
        end
        return h;
    endfunction

    function automatic byte_q_t str2q(input string s);
        byte_q_t q;
        for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
        return q;
    endfunction

    // Behavioural core: result computed on start, ready after a fixed latency.
    logic [255:0] core_state;
    int unsigned  core_busy;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            core_state     <= '0;
            core_busy      <= 0;
            bus.core_ready <= 1'b0;
        end else if (bus.core_start) begin
            core_state     <= compress(bus.core_first_run ? IV : core_state, bus.core_block);
            core_busy      <= CORE_LAT;
            bus.core_ready <= 1'b0;
        end else if (core_busy != 0) begin
            core_busy <= core_busy - 1;
            if (core_busy == 1) bus.core_ready <= 1'b1;
        end
    end
    assign bus.core_hash = core_state;

    // Block log plus protocol watch between each start and the matching core_ready.
    logic         fr_log [$];
    logic [511:0] blk_log [$];
    logic         busy_m = 1'b0;
    logic [511:0] held_blk;
    int           ready_viol = 0, block_viol = 0, restart_viol = 0;
    always @(negedge clk) begin
        if (rst) begin
            busy_m <= 1'b0;
        end else if (bus.core_start === 1'b1) begin
            if (busy_m) restart_viol <= restart_viol + 1;
            fr_log.push_back(bus.core_first_run);
            blk_log.push_back(bus.core_block);
            held_blk <= bus.core_block;
            busy_m   <= 1'b1;
        end else if (busy_m) begin
            if (bus.s_ready !== 1'b0) ready_viol <= ready_viol + 1;
            if (bus.core_block !== held_blk) block_viol <= block_viol + 1;
            if (bus.core_ready === 1'b1) busy_m <= 1'b0;
        end
    end

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_s_ready"},        bus.s_ready,        0);
        check({tag, "_core_start"},     bus.core_start,     0);
        check({tag, "_core_first_run"}, bus.core_first_run, 0);
        check({tag, "_digest_valid"},   bus.digest_valid,   0);
        check({tag, "_digest"},         bus.digest,         0);
        check({tag, "_core_block"},     bus.core_block,     0);
    endtask

    // Presents one beat from a negedge and returns at the negedge after it was taken.
    task automatic send_beat(input logic [7:0] d, input logic last, input logic nob, input int unsigned gap);
        int unsigned guard;
        bus.s_valid = 1'b0;
        repeat (gap) @(negedge clk);
        bus.s_data   = d;
        bus.s_last   = last;
        bus.s_nobyte = nob;
        bus.s_valid  = 1'b1;
        guard = 0;
        while (bus.s_ready !== 1'b1 && guard < LIMIT) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= LIMIT) check("beat_accept_timeout", bus.s_ready, 1);
        @(negedge clk);
    endtask

    task automatic run_msg(input string tag, input byte_q_t m, input bit late, input int unsigned gap_max,
                           input int unsigned ack_dly, output logic [255:0] dig);
        int unsigned  n, guard, bad, exp_blocks;
        logic [15:0]  fr_obs;
        fr_log.delete();
        blk_log.delete();
        n = m.size();
        for (int unsigned i = 0; i < n; i++)
            send_beat(m[i], (i == n - 1) && !late, 1'b0, $urandom_range(gap_max, 0));
        if (n == 0 || late) send_beat(8'h00, 1'b1, 1'b1, $urandom_range(gap_max, 0));
        bus.s_valid  = 1'b0;
        bus.s_last   = 1'b0;
        bus.s_nobyte = 1'b0;
        guard = 0;
        while (bus.digest_valid !== 1'b1 && guard < LIMIT) begin
            @(negedge clk);
            guard++;
        end
        check({tag, "_digest_valid_seen"}, bus.digest_valid, 1);
        dig = bus.digest;
        exp_blocks = (n + 8) / 64 + 1;
        check({tag, "_blocks"}, fr_log.size(), exp_blocks);
        fr_obs = '0;
        for (int i = 0; i < fr_log.size() && i < 16; i++) fr_obs[i] = fr_log[i];
        check({tag, "_first_run"}, fr_obs, 16'd1);
        check({tag, "_digest_model"}, dig, sha_ref(m));
        bad = 0;
        repeat (ack_dly) begin
            @(negedge clk);
            if (bus.digest_valid !== 1'b1 || bus.digest !== dig || bus.s_ready !== 1'b0) bad++;
        end
        check({tag, "_hold_until_ack"}, bad, 0);
        bus.digest_ack = 1'b1;
        @(negedge clk);
        bus.digest_ack = 1'b0;
        check({tag, "_valid_after_ack"}, bus.digest_valid, 0);
        check({tag, "_ready_after_ack"}, bus.s_ready, 1);
    endtask

    initial begin
        byte_q_t      m;
        logic [255:0] dig;
        int unsigned  lens [10];
        rst = 1'b1;
        bus.s_valid    = 1'b0;
        bus.s_data     = 8'h00;
        bus.s_last     = 1'b0;
        bus.s_nobyte   = 1'b0;
        bus.digest_ack = 1'b0;
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        rst = 1'b0;

        run_msg("abc", str2q("abc"), 1'b0, 0, 0, dig);
        check("abc_kat", dig, KAT_ABC);

        m.delete();
        run_msg("empty", m, 1'b0, 1, 1, dig);
        check("empty_kat", dig, KAT_EMPTY);
        check("empty_word0", blk_log[0][511:480], 32'h80000000);
        check("empty_word15", blk_log[0][31:0], 32'h00000000);

        run_msg("two_blk", str2q("abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq"), 1'b0, 1, 2, dig);
        check("two_blk_kat", dig, KAT_56);

        m.delete();
        for (int i = 0; i < 64; i++) m.push_back(8'h00);
        run_msg("zero64", m, 1'b0, 0, 0, dig);
        check("zero64_blk1", blk_log[0], 512'h0);
        check("zero64_blk2_word0", blk_log[1][511:480], 32'h80000000);
        check("zero64_blk2_word15", blk_log[1][31:0], 32'h00000200);

        run_msg("abc_ack20", str2q("abc"), 1'b0, 0, 20, dig);
        check("abc_ack20_kat", dig, KAT_ABC);

        // Abort a message while its first block is inside the core.
        for (int i = 0; i < 64; i++) send_beat(8'h11, 1'b0, 1'b0, 0);
        bus.s_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check_outputs_zero("mid_wait_reset");
        @(negedge clk);
        rst = 1'b0;
        run_msg("abc_after_rst", str2q("abc"), 1'b0, 0, 0, dig);
        check("abc_after_rst_kat", dig, KAT_ABC);

        lens = '{55, 56, 57, 63, 64, 65, 119, 120, 128, 0};
        lens[9] = $urandom_range(140, 1);
        for (int r = 0; r < 10; r++) begin
            m.delete();
            for (int unsigned i = 0; i < lens[r]; i++) m.push_back(8'($urandom));
            run_msg($sformatf("rand_len%0d", lens[r]), m, 1'($urandom_range(1, 0)), 2,
                    $urandom_range(3, 0), dig);
        end

        check("no_ready_during_core", ready_viol, 0);
        check("block_stable_during_core", block_viol, 0);
        check("no_restart_before_ready", restart_viol, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, fails);
        $fatal(1, "watchdog");
    end

endmodule
